// File: rtl/lsu.sv
// Load/store unit: one byte/halfword/word access at a time against a single-port
// RAM with one-cycle registered reads and byte-masked writes.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t          state;
  state_t          state_next;
  logic            handshake;
  logic            req_err;
  logic            lat_we;
  logic [2:0]      lat_funct3;
  logic [1:0]      lat_offset;
  logic [XLEN-1:0] store_data;
  logic [3:0]      store_mask;
  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_data;

  assign handshake = req_valid & req_ready;

  // Misaligned or unsupported requests are answered directly from IDLE.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_we;
      F3_HU:   req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // Store data is replicated into every lane; the mask selects the live bytes.
  always_comb begin
    store_data = req_wdata;
    store_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        store_data = {4{req_wdata[7:0]}};
        store_mask = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        store_data = {2{req_wdata[15:0]}};
        store_mask = 4'b0011 << req_addr[1:0];
      end
      default: begin
        store_data = req_wdata;
        store_mask = 4'b1111;
      end
    endcase
  end

  assign rdata_shifted = mem_rdata >> {lat_offset, 3'b000};

  always_comb begin
    load_data = rdata_shifted;
    case (lat_funct3)
      F3_B:    load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_H:    load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_BU:   load_data = {24'h0, rdata_shifted[7:0]};
      F3_HU:   load_data = {16'h0, rdata_shifted[15:0]};
      default: load_data = rdata_shifted;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = req_err ? RESP : ISSUE;
        end
      end
      ISSUE:   state_next = lat_we ? RESP : WAIT;
      WAIT:    state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake-side outputs.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // Memory-port and response registers. The strobes are loaded at the handshake
  // edge so they are visible for exactly the ISSUE cycle, and cleared elsewhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_offset <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rstrb  <= 1'b0;
      mem_wmask  <= 4'b0000;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      mem_rstrb <= 1'b0;
      mem_wmask <= 4'b0000;
      case (state)
        IDLE: begin
          if (handshake) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_offset <= req_addr[1:0];
            if (req_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[XLEN-1:2], 2'b00};
              if (req_we) begin
                mem_wdata <= store_data;
                mem_wmask <= store_mask;
              end else begin
                mem_rstrb <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (lat_we) begin
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        WAIT: begin
          resp_err   <= 1'b0;
          resp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that initiates single-port memory accesses on behalf of the core. It accepts one byte/halfword/word load or store request at a time over a valid/ready handshake. It drives the `mem_*` port of the on-chip RAM, which has one-cycle registered read latency and byte-masked writes. It aligns store data and masks, extracts and sign/zero-extends load data, flags misaligned or illegal requests without touching memory, and returns exactly one response per request.

## Interface
Parameters:
- `XLEN`, 32, data/address width; only 32 is supported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only).
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response pulse; no back-pressure.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal request; qualified by `resp_valid`.
- `mem_addr`  out  XLEN  word-aligned byte address `{req_addr[31:2],2'b00}`.
- `mem_rstrb`  out  1  read strobe.
- `mem_rdata`  in  XLEN  read data, valid the cycle after `mem_rstrb`.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_wmask`  out  4  byte write enables.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid & req_ready`) latches `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
  - Error: -> RESP with `resp_err`=1.
  - Otherwise -> ISSUE.
- Error conditions:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - funct3 ∉ {000,001,010,100,101}.
  - Store with funct3 100 or 101.
  - Errors never assert `mem_rstrb` or `mem_wmask`.
- ISSUE (exactly one cycle): outputs registered from the latched request.
  - Load: `mem_rstrb`=1, `mem_wmask`=0; -> WAIT.
  - Store B: `mem_wdata`={4{wdata[7:0]}}, `mem_wmask`=4'b0001<<addr[1:0].
  - Store H: `mem_wdata`={2{wdata[15:0]}}, `mem_wmask`=4'b0011<<addr[1:0].
  - Store W: `mem_wdata`=wdata, `mem_wmask`=4'b1111.
  - Store: -> RESP.
- WAIT: sample `mem_rdata`.
  - Shift right by 8*addr[1:0].
  - Take the low 8 bits (B/BU) or 16 bits (H/HU); sign-extend for B/H, zero-extend for BU/HU; W passes through.
  - Register the result into `resp_rdata`; -> RESP.
- RESP (one cycle): `resp_valid`=1, `resp_err` per request; -> IDLE.
- Outside ISSUE, `mem_rstrb`=0 and `mem_wmask`=0. `mem_addr` and `mem_wdata` hold their last values.
- `resp_rdata` and `resp_err` hold until the next RESP. Consumers must use them only while `resp_valid`=1.

## Timing
- Reset (async, while `resetn`=0): state IDLE; `req_ready`=1; `resp_valid`, `resp_err`, `mem_rstrb`, `mem_wmask` = 0; `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset asserted mid-transaction aborts it: no response, and any ISSUE-cycle write strobe is removed immediately.
- Handshake at edge T (cycle 0):
  - Load: ISSUE in cycle 1, WAIT in cycle 2, `resp_valid` in cycle 3, `req_ready` high again in cycle 4. Throughput is 1 load per 4 cycles.
  - Store: ISSUE in cycle 1 (write committed at that edge), `resp_valid` in cycle 2, IDLE in cycle 3.
  - Error: `resp_valid`+`resp_err` in cycle 1, IDLE in cycle 2.
- A new `req_valid` during a busy state is ignored until IDLE. The requester holds it.
- `resp_valid` never asserts in two consecutive cycles.

## Test plan
- Memory word 0x10 = 0x8899AABB; load B, addr 0x13 -> `resp_rdata`=0xFFFFFF88, `resp_err`=0; load BU, same addr -> 0x00000088; response 3 cycles after handshake.
- Same word; load H, addr 0x12 -> 0xFFFF8899; load HU, addr 0x10 -> 0x0000AABB; load W, addr 0x10 -> 0x8899AABB.
- Store B, data 0x000000C3, addr 0x21 -> one ISSUE cycle with `mem_wmask`=0010 and `mem_wdata`=0xC3C3C3C3; a later word read of 0x20 shows only byte 1 changed.
- Misaligned load W at addr 0x06, store H at addr 0x03, and store funct3=100 -> each gives `resp_err`=1 one cycle after handshake, with `mem_rstrb`/`mem_wmask` never asserted.
- Back-to-back: hold `req_valid` high with a load followed by a store -> second handshake only after RESP returns to IDLE (cycle 4); exactly two `resp_valid` pulses.
- Drop `resetn` during WAIT -> all outputs go to reset values asynchronously, with no `resp_valid`; after release, `req_ready`=1 and a fresh load completes normally.
